// File: rtl/sha256_compress.sv
// sha256_compress
// SHA-256 compression stage fed by an upstream message-schedule generator.
// Each accepted schedule word W[t] runs one compression round. After the
// 64th word, one FINAL cycle adds the working variables into H0..H7 and
// presents the digest. The hash state carries across chunks until hash_init.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   hash_init    : synchronous reload of H0..H7 with IV, aborts any chunk
//   w_in         : schedule word W[t]
//   w_in_vaild   : w_in is valid this cycle (no backpressure)
//   busy         : chunk in progress (ROUND or FINAL)
//   chunk_done   : one-cycle pulse after H0..H7 were updated
//   digest       : {H0,...,H7}, H0 in [255:224]
//   digest_vaild : digest holds a completed hash state
//   w_overrun    : one-cycle pulse, a word arrived in FINAL and was dropped
//
// State  | meaning
// IDLE   | waiting for W[0]; rounds read H0..H7 (t == 0)
// ROUND  | rounds 1..63 in progress, one per valid word, gaps hold state
// FINAL  | single cycle folding a..h into H0..H7

module sha256_compress (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hash_init,
   input  logic [31:0]   w_in,
   input  logic          w_in_vaild,
   output logic          busy,
   output logic          chunk_done,
   output logic [255:0]  digest,
   output logic          digest_vaild,
   output logic          w_overrun
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   // Element 0 is H0; packed element 7 sits at the MSB end of the literal.
   localparam logic [7:0][31:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   state_t            state_q, state_d;
   logic [5:0]        t_q, t_d;
   logic [7:0][31:0]  h_q, h_d;
   logic [7:0][31:0]  v_q, v_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              dv_q, dv_d;
   logic              ovr_q, ovr_d;

   logic [7:0][31:0]  src;
   logic [7:0][31:0]  rnd;
   logic [31:0]       ra, rb, rc, rd, re, rf, rg, rh;
   logic [31:0]       sig0, sig1, ch, maj, t1, t2;

   // Round datapath. Round 0 reads H directly so a chunk needs no setup cycle.
   always_comb begin
      src  = (t_q == 6'd0) ? h_q : v_q;
      ra   = src[0];
      rb   = src[1];
      rc   = src[2];
      rd   = src[3];
      re   = src[4];
      rf   = src[5];
      rg   = src[6];
      rh   = src[7];
      sig1 = {re[5:0], re[31:6]} ^ {re[10:0], re[31:11]} ^ {re[24:0], re[31:25]};
      sig0 = {ra[1:0], ra[31:2]} ^ {ra[12:0], ra[31:13]} ^ {ra[21:0], ra[31:22]};
      ch   = (re & rf) ^ (~re & rg);
      maj  = (ra & rb) ^ (ra & rc) ^ (rb & rc);
      t1   = rh + sig1 + ch + K_TAB[t_q] + w_in;
      t2   = sig0 + maj;
      rnd[0] = t1 + t2;
      rnd[1] = ra;
      rnd[2] = rb;
      rnd[3] = rc;
      rnd[4] = rd + t1;
      rnd[5] = re;
      rnd[6] = rf;
      rnd[7] = rg;
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      h_d     = h_q;
      v_d     = v_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      dv_d    = dv_q;
      if (hash_init) begin
         // Any word this cycle is dropped; a pending FINAL update is cancelled.
         h_d     = IV;
         t_d     = 6'd0;
         state_d = S_IDLE;
         dv_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_in_vaild) begin
                  v_d     = rnd;
                  t_d     = t_q + 6'd1;
                  state_d = S_ROUND;
                  dv_d    = 1'b0;
               end
            end
            S_ROUND: begin
               if (w_in_vaild) begin
                  v_d = rnd;
                  t_d = t_q + 6'd1;   // wraps to 0 after round 63
                  if (t_q == 6'd63) begin
                     state_d = S_FINAL;
                  end
               end
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) begin
                  h_d[i] = h_q[i] + v_q[i];
               end
               done_d  = 1'b1;
               dv_d    = 1'b1;
               ovr_d   = w_in_vaild;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         t_q     <= 6'd0;
         h_q     <= IV;
         v_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dv_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         h_q     <= h_d;
         v_q     <= v_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dv_q    <= dv_d;
         ovr_q   <= ovr_d;
      end
   end

   assign busy         = busy_q;
   assign chunk_done   = done_q;
   assign digest_vaild = dv_q;
   assign w_overrun    = ovr_q;
   assign digest       = {h_q[0], h_q[1], h_q[2], h_q[3],
                          h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_compress.sv
module tb_sha256_compress;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hash_init;
   logic [31:0]   w_in;
   logic          w_in_vaild;
   logic          busy;
   logic          chunk_done;
   logic [255:0]  digest;
   logic          digest_vaild;
   logic          w_overrun;

   sha256_compress dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hash_init    (hash_init),
      .w_in         (w_in),
      .w_in_vaild   (w_in_vaild),
      .busy         (busy),
      .chunk_done   (chunk_done),
      .digest       (digest),
      .digest_vaild (digest_vaild),
      .w_overrun    (w_overrun)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   int tests = 0;
   int fails = 0;
   int done_pulses = 0;
   int busy_gap_err = 0;

   logic [31:0] mh [8];
   logic [31:0] sched [64];
   logic [31:0] msg [$];

   always @(negedge clk) if (chunk_done === 1'b1) done_pulses++;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] mh_vec();
      return {mh[0], mh[1], mh[2], mh[3], mh[4], mh[5], mh[6], mh[7]};
   endfunction

   task automatic model_reset();
      mh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   endtask

   // Pads a byte string into 32-bit big-endian words in msg.
   task automatic load_msg(input string s);
      byte unsigned     b [$];
      longint unsigned  bits;
      msg.delete();
      for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
      b.push_back(8'h80);
      while (b.size() % 64 != 56) b.push_back(8'h00);
      bits = 64'(s.len()) * 64'd8;
      for (int i = 7; i >= 0; i--) b.push_back(8'(bits >> (8 * i)));
      for (int i = 0; i < b.size(); i += 4) msg.push_back({b[i], b[i+1], b[i+2], b[i+3]});
   endtask

   task automatic make_sched(input int blk);
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) sched[t] = msg[blk * 16 + t];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3);
         s1 = rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10);
         sched[t] = sched[t-16] + s0 + sched[t-7] + s1;
      end
   endtask

   task automatic model_compress();
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      v = mh;
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + sched[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) mh[i] = mh[i] + v[i];
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      hash_init = 1'b1;
      tick();
      hash_init = 1'b0;
      model_reset();
   endtask

   // Streams sched[0..nwords-1] with 0..gap_max idle cycles before each word.
   task automatic drive_words(input int nwords, input int gap_max);
      int g;
      for (int t = 0; t < nwords; t++) begin
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int i = 0; i < g; i++) begin
            w_in_vaild = 1'b0;
            w_in       = $urandom;
            tick();
            if (t > 0 && busy !== 1'b1) busy_gap_err++;
         end
         w_in       = sched[t];
         w_in_vaild = 1'b1;
         tick();
      end
      w_in_vaild = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (chunk_done !== 1'b1 && cyc < 8);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; hash_init = 1'b0; w_in_vaild = 1'b0; w_in = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      model_reset();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (chunk_done !== 1'b0) begin fails++; $display("FAIL reset_chunk_done: got %b want 0", chunk_done); end
      tests++; if (digest_vaild !== 1'b0) begin fails++; $display("FAIL reset_digest_vaild: got %b want 0", digest_vaild); end
      tests++; if (w_overrun !== 1'b0) begin fails++; $display("FAIL reset_w_overrun: got %b want 0", w_overrun); end
      tests++; if (digest !== IV_D) begin fails++; $display("FAIL reset_digest: got %h want %h", digest, IV_D); end
   endtask

   task automatic test_abc();
      int cyc;
      do_init();
      load_msg("abc"); make_sched(0); model_compress();
      drive_words(64, 0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abc_busy_final: got %b want 1", busy); end
      tests++; if (digest !== IV_D) begin fails++; $display("FAIL abc_digest_pre: got %h want %h", digest, IV_D); end
      wait_done(cyc);
      tests++; if (cyc !== 1) begin fails++; $display("FAIL abc_latency: got %0d cycles want 1 after W63", cyc); end
      tests++; if (digest !== ABC_D) begin fails++; $display("FAIL abc_digest: got %h want %h", digest, ABC_D); end
      tests++; if (digest !== mh_vec()) begin fails++; $display("FAIL abc_model: got %h want %h", digest, mh_vec()); end
      tests++; if (digest_vaild !== 1'b1) begin fails++; $display("FAIL abc_digest_vaild: got %b want 1", digest_vaild); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abc_busy_after: got %b want 0", busy); end
      tick();
      tests++; if (chunk_done !== 1'b0) begin fails++; $display("FAIL abc_done_one_cycle: got %b want 0", chunk_done); end
   endtask

   task automatic test_empty_gaps();
      int cyc;
      do_init();
      load_msg(""); make_sched(0); model_compress();
      busy_gap_err = 0;
      drive_words(64, 5);
      wait_done(cyc);
      tests++; if (busy_gap_err !== 0) begin fails++; $display("FAIL empty_busy_gaps: got %0d drops want 0", busy_gap_err); end
      tests++; if (cyc !== 1) begin fails++; $display("FAIL empty_latency: got %0d want 1", cyc); end
      tests++; if (digest !== EMPTY_D) begin fails++; $display("FAIL empty_digest: got %h want %h", digest, EMPTY_D); end
   endtask

   task automatic test_two_block();
      int cyc, start;
      do_init();
      start = done_pulses;
      load_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      make_sched(0); model_compress();
      drive_words(64, 0);
      wait_done(cyc);
      tests++; if (digest !== mh_vec()) begin fails++; $display("FAIL two_mid_digest: got %h want %h", digest, mh_vec()); end
      make_sched(1); model_compress();
      drive_words(64, 0);
      wait_done(cyc);
      tests++; if (digest !== TWO_D) begin fails++; $display("FAIL two_digest: got %h want %h", digest, TWO_D); end
      tick();
      tests++; if (done_pulses - start !== 2) begin fails++; $display("FAIL two_done_pulses: got %0d want 2", done_pulses - start); end
   endtask

   task automatic test_overrun();
      do_init();
      load_msg("abc"); make_sched(0); model_compress();
      drive_words(64, 0);
      w_in = $urandom; w_in_vaild = 1'b1;
      tick();
      w_in_vaild = 1'b0;
      tests++; if (w_overrun !== 1'b1) begin fails++; $display("FAIL ovr_pulse: got %b want 1", w_overrun); end
      tests++; if (chunk_done !== 1'b1) begin fails++; $display("FAIL ovr_done: got %b want 1", chunk_done); end
      tests++; if (digest !== ABC_D) begin fails++; $display("FAIL ovr_digest: got %h want %h", digest, ABC_D); end
      tick();
      tests++; if (w_overrun !== 1'b0) begin fails++; $display("FAIL ovr_one_cycle: got %b want 0", w_overrun); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovr_no_start: got %b want 0", busy); end
   endtask

   task automatic test_hash_init_abort();
      int cyc;
      load_msg("abc"); make_sched(0);
      drive_words(30, 1);
      hash_init = 1'b1; w_in = sched[30]; w_in_vaild = 1'b1;
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL init_abort_busy: got %b want 0", busy); end
      tests++; if (digest !== IV_D) begin fails++; $display("FAIL init_abort_digest: got %h want %h", digest, IV_D); end
      tests++; if (digest_vaild !== 1'b0) begin fails++; $display("FAIL init_abort_dv: got %b want 0", digest_vaild); end
      w_in = $urandom;
      tick();
      hash_init = 1'b0; w_in_vaild = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL init_word_dropped: got %b want 0", busy); end
      model_reset(); model_compress();
      drive_words(64, 0);
      tests++; if (digest_vaild !== 1'b0) begin fails++; $display("FAIL init_dv_pending: got %b want 0", digest_vaild); end
      wait_done(cyc);
      tests++; if (digest !== ABC_D) begin fails++; $display("FAIL init_abc_digest: got %h want %h", digest, ABC_D); end
      tests++; if (digest_vaild !== 1'b1) begin fails++; $display("FAIL init_abc_dv: got %b want 1", digest_vaild); end
      // hash_init landing on FINAL must cancel the H update.
      drive_words(64, 0);
      hash_init = 1'b1;
      tick();
      hash_init = 1'b0;
      model_reset();
      tests++; if (chunk_done !== 1'b0) begin fails++; $display("FAIL init_final_done: got %b want 0", chunk_done); end
      tests++; if (digest !== IV_D) begin fails++; $display("FAIL init_final_digest: got %h want %h", digest, IV_D); end
      tests++; if (digest_vaild !== 1'b0) begin fails++; $display("FAIL init_final_dv: got %b want 0", digest_vaild); end
   endtask

   task automatic test_random_back_to_back();
      int cyc;
      do_init();
      busy_gap_err = 0;
      for (int c = 0; c < 4; c++) begin
         msg.delete();
         for (int i = 0; i < 16; i++) msg.push_back($urandom);
         make_sched(0); model_compress();
         drive_words(64, c % 3);
         wait_done(cyc);
         tests++; if (cyc !== 1) begin fails++; $display("FAIL rand_latency[%0d]: got %0d want 1", c, cyc); end
         tests++; if (digest !== mh_vec()) begin fails++; $display("FAIL rand_digest[%0d]: got %h want %h", c, digest, mh_vec()); end
      end
      tests++; if (busy_gap_err !== 0) begin fails++; $display("FAIL rand_busy_gaps: got %0d drops want 0", busy_gap_err); end
   endtask

   task automatic test_reset_midchunk();
      int cyc;
      load_msg("abc"); make_sched(0);
      drive_words(40, 0);
      #2 rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      tests++; if (digest !== IV_D) begin fails++; $display("FAIL rstmid_digest: got %h want %h", digest, IV_D); end
      tests++; if (digest_vaild !== 1'b0) begin fails++; $display("FAIL rstmid_dv: got %b want 0", digest_vaild); end
      tests++; if (chunk_done !== 1'b0 || w_overrun !== 1'b0) begin fails++; $display("FAIL rstmid_pulses: got %b%b want 00", chunk_done, w_overrun); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      model_reset(); model_compress();
      drive_words(64, 0);
      wait_done(cyc);
      tests++; if (digest !== ABC_D) begin fails++; $display("FAIL rstmid_abc: got %h want %h", digest, ABC_D); end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_empty_gaps();
      test_two_block();
      test_overrun();
      test_hash_init_abort();
      test_random_back_to_back();
      test_reset_midchunk();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
